music_player: RTL and testbench

Song sequencer that reads the synchronous note ROMs (music1/music2/music3) and drives a square-wave speaker output. Each ROM word is a half-period count in system clocks (50 MHz / f / 2). The player steps through the addresses, holds each note for a fixed duration and toggles the speaker at the stored half-period. It sits between the song ROM and the audio output pin, with start/stop control from the top-level FSM.

---
 rtl/music_pkg.sv | 20 ++
 rtl/music_if.sv | 24 ++
 rtl/tone_gen.sv | 33 +++
 rtl/music_player.sv | 119 +++++++++++
 tb/tb_music_player.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the song sequencer.
package music_pkg;

  localparam int unsigned SYS_CLK_HZ = 50_000_000;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY
  } state_t;

  // Half-period in system clocks for a tone of the given frequency.
  function automatic int unsigned half_period(input int unsigned freq);
    return SYS_CLK_HZ / freq / 2;
  endfunction

endpackage

// File: rtl/music_if.sv
// Control, ROM and audio signals between the song sequencer and its host.
interface music_if #(
  parameter int unsigned ADDR_W = music_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = music_pkg::DEF_DATA_W
);
  logic              start;
  logic              stop;
  logic              loop;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              speaker;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, loop, rom_data,
    input  rom_addr, speaker, busy, done
  );

  modport slave (
    input  start, stop, loop, rom_data,
    output rom_addr, speaker, busy, done
  );
endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: toggles speaker every `half` enabled clocks.
module tone_gen #(
  parameter int unsigned DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] half,
  output logic              speaker
);

  logic [DATA_W-1:0] tone_cnt;

  // A zero half-period is a rest: the counter and speaker stay idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      speaker  <= 1'b0;
    end else if (clear) begin
      tone_cnt <= '0;
      speaker  <= 1'b0;
    end else if (enable && (half != '0)) begin
      if (tone_cnt == half - DATA_W'(1)) begin
        tone_cnt <= '0;
        speaker  <= ~speaker;
      end else begin
        tone_cnt <= tone_cnt + DATA_W'(1);
      end
    end
  end

endmodule

// File: rtl/music_player.sv
// Song sequencer: walks the note ROM, holds each note NOTE_LEN clocks, drives the speaker.
module music_player
  import music_pkg::*;
#(
  parameter int unsigned NUM_NOTES = 31,
  parameter int unsigned NOTE_LEN  = 12_500_000,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W
) (
  input logic     clk,
  input logic     rst_n,
  music_if.slave  bus
);

  localparam int unsigned       NOTE_W    = $clog2(NOTE_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NOTES - 1);
  localparam logic [NOTE_W-1:0] LAST_TICK = NOTE_W'(NOTE_LEN - 1);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   rom_addr, rom_addr_d;
  logic [NOTE_W-1:0]   note_cnt, note_cnt_d;
  logic [DATA_W-1:0]   half_reg, half_d;
  logic                done, done_d;
  logic                busy;
  logic                tone_clear, tone_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      note_cnt <= '0;
      half_reg <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      rom_addr <= rom_addr_d;
      note_cnt <= note_cnt_d;
      half_reg <= half_d;
      done     <= done_d;
      busy     <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d    = state;
    rom_addr_d = rom_addr;
    note_cnt_d = note_cnt;
    half_d     = half_reg;
    done_d     = 1'b0;
    tone_clear = 1'b0;
    tone_en    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          rom_addr_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        tone_clear = 1'b1;
        state_d    = LOAD;
      end
      LOAD: begin
        half_d     = bus.rom_data;
        note_cnt_d = '0;
        tone_clear = 1'b1;
        state_d    = PLAY;
      end
      PLAY: begin
        tone_en = 1'b1;
        if (note_cnt == LAST_TICK) begin
          // Note boundary: the speaker is forced low through FETCH/LOAD.
          note_cnt_d = '0;
          tone_clear = 1'b1;
          if (rom_addr < LAST_ADDR) begin
            rom_addr_d = rom_addr + ADDR_W'(1);
            state_d    = FETCH;
          end else if (bus.loop) begin
            rom_addr_d = '0;
            state_d    = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          note_cnt_d = note_cnt + NOTE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Stop overrides every other event.
    if (bus.stop) begin
      state_d    = IDLE;
      rom_addr_d = '0;
      note_cnt_d = '0;
      half_d     = '0;
      done_d     = 1'b0;
      tone_clear = 1'b1;
      tone_en    = 1'b0;
    end
  end

  tone_gen #(.DATA_W(DATA_W)) u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tone_clear),
    .enable  (tone_en),
    .half    (half_reg),
    .speaker (bus.speaker)
  );

  assign bus.rom_addr = rom_addr;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_music_player.sv
// Scoreboard bench for music_player: 4-note ROM {3,5,0,2}, 20-clock notes.
module tb_music_player;

  typedef struct packed {
    logic [4:0] addr;
    logic       spk;
    logic       busy;
    logic       done;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  music_if #(.ADDR_W(5), .DATA_W(20)) bus ();

  music_player #(
    .NUM_NOTES (4),
    .NOTE_LEN  (20),
    .ADDR_W    (5),
    .DATA_W    (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int rom [4] = '{3, 5, 0, 2};

  // Behavioural synchronous ROM.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rom_data <= '0;
    else        bus.rom_data <= 20'(rom[bus.rom_addr[1:0]]);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_assert = 0;
  int    n_fail   = 0;
  exp_t  q[$];
  snap_t exp_prev = '0;
  snap_t last_obs = '0;
  bit    mon_en   = 1'b0;

  function automatic snap_t obs();
    return snap_t'({bus.rom_addr, bus.speaker, bus.busy, bus.done});
  endfunction

  // Monitor: every visible output change is popped against the scoreboard.
  always @(negedge clk) begin
    snap_t s;
    exp_t  e;
    if (mon_en) begin
      s = obs();
      if (s != last_obs) begin
        last_obs = s;
        n_assert++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event cyc=%0d got addr=%0d spk=%0b busy=%0b done=%0b",
                   cyc, s.addr, s.spk, s.busy, s.done);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.s != s) begin
            n_fail++;
            $display("FAIL event got cyc=%0d addr=%0d spk=%0b busy=%0b done=%0b, need cyc=%0d addr=%0d spk=%0b busy=%0b done=%0b",
                     cyc, s.addr, s.spk, s.busy, s.done,
                     e.cyc, e.s.addr, e.s.spk, e.s.busy, e.s.done);
          end
        end
      end
    end
  end

  task automatic push_exp(input int c, input int a, input bit spk, input bit busy, input bit done);
    snap_t s;
    exp_t  e;
    s = snap_t'({5'(a), spk, busy, done});
    if (s != exp_prev) begin
      e.cyc = c;
      e.s   = s;
      q.push_back(e);
      exp_prev = s;
    end
  endtask

  // One note whose FETCH is visible at cycle c0; PLAY cycles 0..last_k.
  task automatic gen_note(input int c0, input int a, input int half, input int last_k);
    push_exp(c0,     a, 1'b0, 1'b1, 1'b0);
    push_exp(c0 + 1, a, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= last_k; k++)
      push_exp(c0 + 2 + k, a, (half == 0) ? 1'b0 : (((k / half) % 2) == 1), 1'b1, 1'b0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(output int p);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    p = cyc + 1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d events pending after %0d cycles, next needed at cyc %0d",
               name, q.size(), budget, q[0].cyc);
      q.delete();
    end
  endtask

  task automatic check_snap(input string name, input snap_t need);
    snap_t s;
    s = obs();
    n_assert++;
    if (s != need) begin
      n_fail++;
      $display("FAIL %s got addr=%0d spk=%0b busy=%0b done=%0b, need addr=%0d spk=%0b busy=%0b done=%0b",
               name, s.addr, s.spk, s.busy, s.done, need.addr, need.spk, need.busy, need.done);
    end
  endtask

  task automatic song_basic(input string name);
    int p;
    pulse_start(p);
    for (int n = 0; n < 4; n++) gen_note(p + 22 * n, n, rom[n], 19);
    push_exp(p + 88, 3, 1'b0, 1'b0, 1'b1);
    push_exp(p + 89, 3, 1'b0, 1'b0, 1'b0);
    wait_drain(name, 120);
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;

    // Reset state, held across clock edges.
    #12;
    check_snap("reset_values", '0);
    repeat (2) @(posedge clk);
    #1;
    check_snap("reset_held", '0);
    rst_n    = 1'b1;
    exp_prev = '0;
    last_obs = obs();
    mon_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic non-looping song.
    song_basic("basic");

    // Loop twice; loop cleared during the second pass.
    bus.loop = 1'b1;
    pulse_start(p);
    for (int pass = 0; pass < 2; pass++)
      for (int n = 0; n < 4; n++) gen_note(p + 88 * pass + 22 * n, n, rom[n], 19);
    push_exp(p + 176, 3, 1'b0, 1'b0, 1'b1);
    push_exp(p + 177, 3, 1'b0, 1'b0, 1'b0);
    wait_until(p + 100);
    bus.loop = 1'b0;
    wait_drain("loop", 150);
    repeat (10) @(posedge clk);
    #1;

    // Stop in note 1 PLAY cycle 10; start pulses while busy and alongside stop are ignored.
    pulse_start(p);
    gen_note(p, 0, 3, 19);
    gen_note(p + 22, 1, 5, 10);
    push_exp(p + 35, 0, 1'b0, 1'b0, 1'b0);
    wait_until(p + 10);
    bus.start = 1'b1;
    wait_until(p + 11);
    bus.start = 1'b0;
    wait_until(p + 34);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    wait_until(p + 35);
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    wait_drain("stop", 10);
    repeat (30) @(posedge clk);
    #1;
    check_snap("stop_idle", '0);

    // Asynchronous reset mid-note while the speaker is high.
    pulse_start(p);
    gen_note(p, 0, 3, 19);
    gen_note(p + 22, 1, 5, 7);
    wait_until(p + 31);
    wait_drain("pre_reset", 1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_snap("async_reset", '0);
    repeat (2) @(posedge clk);
    #1;
    check_snap("async_reset_held", '0);
    rst_n    = 1'b1;
    exp_prev = '0;
    last_obs = obs();
    mon_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    song_basic("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
